// File: rtl/common_pkg.sv
// Shared register-file dimensions and register-dump transmitter types.
// REGDUMP_CHECKSUM_EN adds the CSUM state to the dump state encoding.
package common_pkg;

  localparam int REGISTER_FILE_ADDRESS_WIDTH = 5;
  localparam int RISC_V_DATA_WIDTH           = 64;
  localparam int REGISTER_FILE_NUM           = 32;

  localparam int REGDUMP_BYTES_PER_REG = RISC_V_DATA_WIDTH / 8;

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_BYTES,
    ST_CSUM,
    ST_FIN
  } regdump_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_BYTES,
    ST_FIN
  } regdump_state_t;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter. ready is also high in the final cycle of the stop
// bit so a waiting byte is accepted with no idle gap on the line.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          active;
  logic          bit_end;
  logic          frame_end;

  assign bit_end   = active && (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign frame_end = bit_end && (bit_cnt == 4'd9);
  assign ready     = !active || frame_end;
  assign tx        = active ? shreg[0] : 1'b1;

  // Load a frame on accept, otherwise shift one bit per bit period until the stop bit ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      active  <= 1'b0;
    end else if (valid && ready) begin
      shreg   <= {1'b1, byte_in, 1'b0};
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (bit_end) begin
        clk_cnt <= '0;
        shreg   <= {1'b1, shreg[9:1]};
        if (bit_cnt == 4'd9) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_tx.sv
// Register-file dump transmitter: walks every register through a spare read
// port and streams a sync byte plus all register bytes (LSB first) over UART.
// Optional feature macro: REGDUMP_CHECKSUM_EN appends an XOR of all register bytes.
//
// state | meaning
// IDLE  | waiting for start, reg_idx held at 0
// HDR   | sending the sync byte and waiting for its stop bit to finish
// FETCH | one cycle: latch r_data for reg_idx into word_q (line idles high)
// BYTES | sending word_q bytes back to back, then waiting for the last stop bit
// CSUM  | sending the XOR checksum byte (checksum builds only)
// FIN   | one-cycle done pulse, busy already low
module regfile_dump_tx
  import common_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_r,
  input  logic [RISC_V_DATA_WIDTH-1:0]           r_data,
  output logic                                   tx,
  output logic                                   busy,
  output logic                                   done
);

  localparam int AW = REGISTER_FILE_ADDRESS_WIDTH;
  localparam int BW = $clog2(REGDUMP_BYTES_PER_REG);

  regdump_state_t                 state_q, state_d;
  logic [AW-1:0]                  reg_idx_q;
  logic [BW-1:0]                  byte_idx_q;
  logic [RISC_V_DATA_WIDTH-1:0]   word_q;
  // Set once the final byte of the current state has been handed to the UART.
  logic                           issued_q;
  logic                           uart_valid;
  logic                           uart_ready;
  logic [7:0]                     uart_byte;
  logic                           uart_accept;
  logic                           byte_last;
  logic                           reg_last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]                     csum_q;
`endif

  assign reg_num_r   = reg_idx_q;
  assign uart_accept = uart_valid && uart_ready;
  assign byte_last   = (byte_idx_q == BW'(REGDUMP_BYTES_PER_REG - 1));
  assign reg_last    = (reg_idx_q == AW'(REGISTER_FILE_NUM - 1));

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .byte_in (uart_byte),
    .valid   (uart_valid),
    .ready   (uart_ready),
    .tx      (tx)
  );

  // Next-state and output decode; a state advances only once its UART frame has fully drained.
  always_comb begin
    state_d    = state_q;
    uart_valid = 1'b0;
    uart_byte  = HDR_BYTE;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_HDR;
      end
      ST_HDR: begin
        uart_valid = !issued_q;
        if (issued_q && uart_ready) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_BYTES;
      end
      ST_BYTES: begin
        uart_byte  = word_q[{byte_idx_q, 3'b000} +: 8];
        uart_valid = !issued_q;
        if (issued_q && uart_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          state_d = reg_last ? ST_CSUM : ST_FETCH;
`else
          state_d = reg_last ? ST_FIN : ST_FETCH;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      ST_CSUM: begin
        uart_byte  = csum_q;
        uart_valid = !issued_q;
        if (issued_q && uart_ready) state_d = ST_FIN;
      end
`endif
      ST_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Register/byte walk counters, fetched word and optional running XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      issued_q   <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      if (state_d != state_q)
        issued_q <= 1'b0;
      else if (uart_accept && (state_q != ST_BYTES || byte_last))
        issued_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          reg_idx_q  <= '0;
          byte_idx_q <= '0;
`ifdef REGDUMP_CHECKSUM_EN
          if (start) csum_q <= '0;
`endif
        end
        ST_FETCH: begin
          word_q     <= r_data;
          byte_idx_q <= '0;
        end
        ST_BYTES: begin
          if (uart_accept) begin
            if (!byte_last) byte_idx_q <= byte_idx_q + 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q <= csum_q ^ uart_byte;
`endif
          end
          if (state_d == ST_FETCH) reg_idx_q <= reg_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: behavioural register file, UART monitor and a
// byte scoreboard filled from the bench's own model of the dump.
module tb_regfile_dump_tx;
  import common_pkg::*;

  localparam int CPB = 4;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int EXP_LEN = 258;
`else
  localparam int EXP_LEN = 257;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_r;
  logic [RISC_V_DATA_WIDTH-1:0]           r_data;
  logic        tx, busy, done;

  logic [63:0] rf [REGISTER_FILE_NUM];
  assign r_data = rf[reg_num_r];

  regfile_dump_tx #(.CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reg_num_r(reg_num_r),
    .r_data(r_data), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] got [300];
  int rx_cnt = 0;
  int done_cnt = 0;
  bit mon_abort = 0;

  typedef struct {
    logic [63:0] rf1;
    logic [63:0] exp_bytes;   // expected dump bytes 9..16, first byte in the MSBs
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (done) done_cnt++;

  // UART monitor: samples mid-bit, hands completed bytes to the scoreboard.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        mon_abort = 0;
        b = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (!mon_abort && rst_n) begin
          chk("stop_bit", 64'(tx), 64'd1);
          if (rx_cnt < 300) got[rx_cnt] = b;
          rx_cnt++;
          if (exp_q.size() == 0) chk("unexpected_byte", 64'(b), 64'hFFFF);
          else chk("sb_byte", 64'(b), 64'(exp_q.pop_front()));
        end
        @(negedge clk);
      end
    end
  end

  task automatic fill_pattern();
    for (int i = 0; i < REGISTER_FILE_NUM; i++) rf[i] = 64'h0101_0101_0101_0101 * 64'(i);
  endtask

  task automatic push_dump();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < REGISTER_FILE_NUM; r++)
      for (int k = 0; k < 8; k++) begin
        exp_q.push_back(rf[r][8*k +: 8]);
        x = x ^ rf[r][8*k +: 8];
      end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Waits for done; optionally pokes start when rx_cnt reaches poke_a/poke_b.
  task automatic wait_done(input int poke_a, input int poke_b);
    bit ok, pa, pb;
    int busy_bad;
    ok = 0; pa = 0; pb = 0; busy_bad = 0;
    for (int n = 0; n < 15000; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin ok = 1; break; end
      if (busy !== 1'b1) busy_bad++;
      if (!pa && rx_cnt == poke_a) begin start = 1'b1; pa = 1; end
      else if (!pb && rx_cnt == poke_b) begin start = 1'b1; pb = 1; end
    end
    start = 1'b0;
    chk("done_seen", 64'(ok), 64'd1);
    chk("busy_during_dump", 64'(busy_bad), 64'd0);
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic post_dump_checks();
    int quiet_bad, cnt0;
    quiet_bad = 0;
    repeat (CPB * 12) @(negedge clk);
    cnt0 = rx_cnt;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet_bad++;
    end
    chk("dump_len", 64'(rx_cnt), 64'(EXP_LEN));
    chk("no_extra_bytes", 64'(rx_cnt), 64'(cnt0));
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_after_done", 64'(quiet_bad), 64'd0);
  endtask

  task automatic run_full(input int poke_a, input int poke_b);
    rx_cnt = 0; done_cnt = 0;
    push_dump();
    pulse_start();
    wait_done(poke_a, poke_b);
    post_dump_checks();
  endtask

  initial begin
    int bad;
    logic [7:0] e;
    vecs[0] = '{64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'hEFCD_AB89_6745_2301};
    vecs[2] = '{64'hFF00_0000_0000_0080, 64'h8000_0000_0000_00FF};
    fill_pattern();

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_reg_num", 64'(reg_num_r), 64'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_100", 64'(bad), 64'd0);

    // Table: RF[1] value and the expected bytes 9..16 of the dump.
    for (int v = 0; v < 3; v++) begin
      fill_pattern();
      rf[1] = vecs[v].rf1;
      run_full(-1, -1);
      for (int k = 0; k < 8; k++) begin
        e = vecs[v].exp_bytes[63 - 8*k -: 8];
        chk("byte_order", 64'(got[9 + k]), 64'(e));
      end
      chk("hdr_byte", 64'(got[0]), 64'hA5);
      chk("last_reg_byte", 64'(got[256]), 64'h1F);
`ifdef REGDUMP_CHECKSUM_EN
      if (v == 0) chk("csum_pattern", 64'(got[257]), 64'h00);
`endif
    end

    // Start while busy is ignored.
    fill_pattern();
    run_full(3, 200);

    // Reset during the data bits of byte 50, then a clean dump.
    rx_cnt = 0; done_cnt = 0;
    push_dump();
    pulse_start();
    bad = 1;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (rx_cnt >= 50) begin bad = 0; break; end
    end
    chk("reach_byte50", 64'(bad), 64'd0);
    bad = 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin bad = 0; break; end
    end
    chk("byte50_start", 64'(bad), 64'd0);
    repeat (10) @(negedge clk);
    mon_abort = 1;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 64'(tx), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_reg_num", 64'(reg_num_r), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    exp_q.delete();
    chk("midrst_quiet_tx", 64'(tx), 64'd1);
    run_full(-1, -1);
    chk("after_rst_hdr", 64'(got[0]), 64'hA5);

`ifdef REGDUMP_CHECKSUM_EN
    for (int i = 0; i < REGISTER_FILE_NUM; i++) rf[i] = 64'h0;
    rf[3] = 64'h0000_0000_0000_005A;
    run_full(-1, -1);
    chk("csum_5a", 64'(got[257]), 64'h5A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
